// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// fetch_unit_pkg : shared ISA field positions, reset defaults and FSM states
// Rev 1.0
// ============================================================================
package fetch_unit_pkg;

  localparam int          ISA_W            = 16;
  localparam int          FIELD_W          = 4;
  localparam int          OPCODE_LSB       = 12;
  localparam int          RD_LSB           = 8;
  localparam int          RS_LSB           = 4;
  localparam int          RT_LSB           = 0;
  localparam int          IMM_W_DEFAULT    = 8;
  localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_unit_instr_decode.sv
`default_nettype none
// ============================================================================
// instr_decode : combinational field split and immediate sign extension
// Rev 1.0
// ============================================================================
module instr_decode
  import fetch_unit_pkg::*;
#(
  parameter int IMM_W = IMM_W_DEFAULT
) (
  input  logic [15:0] inst,
  output logic [3:0]  opcode,
  output logic [3:0]  rd,
  output logic [3:0]  rs,
  output logic [3:0]  rt,
  output logic [15:0] imm
);

  assign opcode = inst[OPCODE_LSB +: FIELD_W];
  assign rd     = inst[RD_LSB +: FIELD_W];
  assign rs     = inst[RS_LSB +: FIELD_W];
  assign rt     = inst[RT_LSB +: FIELD_W];

  generate
    if (IMM_W < ISA_W) begin : g_sext
      assign imm = {{(ISA_W - IMM_W){inst[IMM_W-1]}}, inst[IMM_W-1:0]};
    end else begin : g_full
      assign imm = inst;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_unit : BOOT/FETCH/HOLD instruction fetch with branch redirect.
// Optional macro FETCH_PERF_EN adds a saturating consumed-instruction counter.
// Rev 1.0
// ============================================================================
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          IMM_W    = IMM_W_DEFAULT
) (
  input  logic        CLK,
  input  logic        Reset,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic [15:0] inst,
  output logic [15:0] inst_pc,
  output logic        inst_valid,
  output logic [3:0]  opcode,
  output logic [3:0]  rd,
  output logic [3:0]  rs,
  output logic [3:0]  rt,
  output logic [15:0] imm
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [15:0]  inst_q, inst_d;
  logic [15:0]  inst_pc_q, inst_pc_d;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q   <= BOOT;
      pc_q      <= RESET_PC;
      inst_q    <= 16'h0000;
      inst_pc_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end

  // A redirect outranks both a completing fetch and a stalled hold.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    unique case (state_q)
      BOOT: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (branch_taken) begin
          pc_d = branch_target;
        end else if (mem_ready) begin
          inst_d    = mem_rdata;
          inst_pc_d = pc_q;
          pc_d      = pc_q + 16'd1;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (branch_taken) begin
          pc_d    = branch_target;
          state_d = FETCH;
        end else if (!stall) begin
          state_d = FETCH;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  assign mem_rd     = (state_q == FETCH);
  assign mem_addr   = pc_q;
  assign inst_valid = (state_q == HOLD);
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;

  instr_decode #(
    .IMM_W (IMM_W)
  ) u_decode (
    .inst   (inst_q),
    .opcode (opcode),
    .rd     (rd),
    .rs     (rs),
    .rt     (rt),
    .imm    (imm)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic        consume;

  assign consume = (state_q == HOLD) && !stall && !branch_taken;

  always_comb begin
    fetch_count_d = fetch_count_q;
    if (consume && (fetch_count_q != 32'hFFFF_FFFF)) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      fetch_count_q <= 32'd0;
    end else begin
      fetch_count_q <= fetch_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
`endif

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000: PC value loaded on reset.
REQ-002 Parameter IMM_W, default 8: width of the immediate field, sign-extended to 16 bits.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high; ports CLK and Reset.
REQ-004 CLK  input  1  rising-edge clock for all state.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 mem_addr  output  16  word address of the instruction fetch.
REQ-007 mem_rd  output  1  fetch request, held until mem_ready.
REQ-008 mem_rdata  input  16  instruction word, valid when mem_ready=1.
REQ-009 mem_ready  input  1  memory completes the request this cycle.
REQ-010 stall  input  1  downstream ALU/memory stage cannot accept.
REQ-011 branch_taken  input  1  redirect request from downstream.
REQ-012 branch_target  input  16  redirect address.
REQ-013 inst  output  16  registered instruction word.
REQ-014 inst_pc  output  16  address of inst.
REQ-015 inst_valid  output  1  inst and its decoded fields are valid.
REQ-016 opcode/rd/rs/rt  output  4 each  fields inst[15:12]/[11:8]/[7:4]/[3:0].
REQ-017 imm  output  16  inst[IMM_W-1:0] sign-extended.

Function
REQ-018 FSM states: BOOT, FETCH, HOLD; the state register changes only on CLK or Reset.
REQ-019 BOOT: outputs idle; next state FETCH unconditionally.
REQ-020 FETCH: mem_rd=1 and mem_addr=pc; on mem_ready, inst<=mem_rdata, inst_pc<=pc, pc<=pc+1, next state HOLD.
REQ-021 FETCH with mem_ready=0: stay, hold mem_addr stable, mem_rd stays high.
REQ-022 HOLD: inst_valid=1 and mem_rd=0; stall=0 means the instruction is consumed this cycle, next state FETCH; stall=1 means stay, with inst and inst_pc unchanged.
REQ-023 Minimum throughput: one instruction per 2 cycles with zero-wait memory.
REQ-024 Fetch-to-valid latency: inst_valid rises the cycle after the mem_ready edge.
REQ-025 branch_taken has priority in any state except BOOT: pc<=branch_target, inst_valid<=0, next state FETCH.
REQ-026 branch_taken with mem_ready in the same FETCH cycle: mem_rdata is discarded and pc does not increment.
REQ-027 branch_taken with stall in HOLD: the branch wins and the held instruction is dropped.
REQ-028 PC arithmetic is modulo 2^16; 16'hFFFF+1 wraps to 16'h0000.
REQ-029 Decoded fields are combinational from the inst register only, never from mem_rdata.

Reset
REQ-030 Reset values: state=BOOT, pc=RESET_PC, inst=16'h0000, inst_pc=16'h0000, inst_valid=0, mem_rd=0, mem_addr=RESET_PC.
REQ-031 Reset mid-fetch aborts the request immediately; a mem_ready arriving during Reset is ignored.

Configuration
REQ-032 Macro FETCH_PERF_EN: when defined, adds output fetch_count (32 bit), incremented on each consumed instruction (HOLD with stall=0 and no branch), saturating at 32'hFFFFFFFF, reset to 0.
REQ-033 Without FETCH_PERF_EN, the port and the counter are absent and all other behaviour is identical.

Structure
REQ-034 Shared include isa_defs.vh: opcode field bit positions, IMM_W default, RESET_PC default, FSM state encodings.
REQ-035 One sub-module, instr_decode, SHALL hold the combinational field split and sign extension; it is reused by the ALU/memory stage.

Verification
REQ-036 Reset, then zero-wait memory returning 16'h1234 at address 0 -> inst=16'h1234, inst_pc=0, opcode=1, rd=2, rs=3, rt=4, imm=16'h0034, inst_valid on cycle 3.
REQ-037 mem_ready delayed 3 cycles at address 5 -> mem_addr=5 held for 4 cycles with mem_rd high, then inst_pc=5.
REQ-038 stall held 4 cycles in HOLD -> inst unchanged, no mem_rd, and the next fetch address is inst_pc+1.
REQ-039 branch_taken=1, branch_target=16'h0040, asserted together with mem_ready -> data dropped, next mem_addr=16'h0040, inst_valid=0.
REQ-040 pc=16'hFFFF fetched -> next mem_addr=16'h0000; inst 16'h00F0 -> imm=16'hFFF0.
REQ-041 FETCH_PERF_EN defined, 10 instructions consumed with one branch flush -> fetch_count=10; Reset asserted mid-fetch -> all outputs at reset values asynchronously.
